// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared mode constants, default taps and width-generic LFSR next-state function.
package lfsr_pkg;
  localparam logic LFSR_GALOIS = 1'b0;
  localparam logic LFSR_FIB = 1'b1;
  localparam logic [4:0] LFSR_TAPS5 = 5'b00100;
  localparam int LFSR_MAXW = 64;
  // q and taps are zero-extended to LFSR_MAXW; only the low w bits are meaningful.
  function automatic logic [LFSR_MAXW-1:0] lfsr_next(input logic [LFSR_MAXW-1:0] q,
                                                    input logic [LFSR_MAXW-1:0] taps,
                                                    input int w, input logic mode);
    logic [LFSR_MAXW-1:0] msb, t, sh;
    msb = LFSR_MAXW'(1) << (w - 1);
    t = taps & (msb - LFSR_MAXW'(1));
    sh = q >> 1;
    return mode == LFSR_FIB ? (sh | ((q[0] ^ (^(q & t))) ? msb : '0))
                            : (sh ^ (q[0] ? (t | msb) : '0));
  endfunction
endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control/status bundle of lfsr_gen.
//   master drives step, load, load_data; slave (the generator) drives q, sout, wrap, zero_err, period.
interface lfsr_gen_if #(parameter int WIDTH = 5, parameter int CW = 16);
  logic step;
  logic load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] q;
  logic sout;
  logic wrap;
  logic zero_err;
  logic [CW-1:0] period;
  modport master(output step, load, load_data, input q, sout, wrap, zero_err, period);
  modport slave(input step, load, load_data, output q, sout, wrap, zero_err, period);
endinterface

// File: rtl/lfsr_next_comb.sv
// lfsr_next_comb: combinational one-step LFSR successor.
//   q in WIDTH current state, n out WIDTH next state.
module lfsr_next_comb
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS5),
  parameter logic MODE = LFSR_GALOIS
) (
  input logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] n
);
  logic [LFSR_MAXW-1:0] n_full;
  assign n_full = lfsr_next(LFSR_MAXW'(q), LFSR_MAXW'(TAPS), WIDTH, MODE);
  assign n = n_full[WIDTH-1:0];
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised PRBS generator with seed load, zero-seed protection and period measurement.
//   clk, reset (sync, active-high); bus: lfsr_gen_if slave (step/load/load_data in; q/sout/wrap/zero_err/period out).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS5),
  parameter logic MODE = LFSR_GALOIS,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  parameter int CW = 16
) (
  input logic clk,
  input logic reset,
  lfsr_gen_if.slave bus
);
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (WIDTH < 3 || WIDTH > LFSR_MAXW) begin : g_bad_width
    $error("lfsr_gen: WIDTH out of range");
  end
  logic [WIDTH-1:0] q, seed_reg, n;
  logic [CW-1:0] cnt, period, cnt_inc;
  logic wrap, zero_err, ld_ok;
  lfsr_next_comb #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_next (.q(q), .n(n));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign ld_ok = bus.load_data != '0;
  // A rejected all-zero load falls back to SEED so the register can never lock up.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
      seed_reg <= SEED;
      cnt <= '0;
      period <= '0;
      wrap <= 1'b0;
      zero_err <= 1'b0;
    end else if (bus.load) begin
      q <= ld_ok ? bus.load_data : SEED;
      seed_reg <= ld_ok ? bus.load_data : SEED;
      zero_err <= !ld_ok;
      cnt <= '0;
      wrap <= 1'b0;
    end else if (bus.step) begin
      q <= n;
      zero_err <= 1'b0;
      wrap <= n == seed_reg;
      cnt <= n == seed_reg ? '0 : cnt_inc;
      if (n == seed_reg) period <= cnt_inc;
    end else begin
      wrap <= 1'b0;
      zero_err <= 1'b0;
    end
  end
  assign bus.q = q;
  assign bus.sout = q[0];
  assign bus.wrap = wrap;
  assign bus.zero_err = zero_err;
  assign bus.period = period;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed vector table plus multi-cycle sequences for lfsr_gen.
module tb_lfsr_gen;
  import lfsr_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  lfsr_gen_if #(.WIDTH(5), .CW(16)) ia ();
  lfsr_gen_if #(.WIDTH(5), .CW(16)) ib ();
  lfsr_gen_if #(.WIDTH(5), .CW(4)) ic ();
  lfsr_gen #(.WIDTH(5), .TAPS(5'b00100), .MODE(LFSR_GALOIS), .SEED(5'b00001), .CW(16))
    dut_a (.clk(clk), .reset(rst), .bus(ia.slave));
  lfsr_gen #(.WIDTH(5), .TAPS(5'b00100), .MODE(LFSR_FIB), .SEED(5'b00001), .CW(16))
    dut_b (.clk(clk), .reset(rst), .bus(ib.slave));
  lfsr_gen #(.WIDTH(5), .TAPS(5'b00100), .MODE(LFSR_GALOIS), .SEED(5'b00001), .CW(4))
    dut_c (.clk(clk), .reset(rst), .bus(ic.slave));
  typedef struct {
    logic r, s, l;
    logic [4:0] d;
    logic [4:0] q;
    logic w, z;
    logic [15:0] p;
  } vec_t;
  vec_t v[11];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic check_a(input string tag, input logic [4:0] q, input logic w, input logic z,
                         input logic [15:0] p);
    chk({tag, "_q"}, 32'(ia.q), 32'(q));
    chk({tag, "_sout"}, 32'(ia.sout), 32'(q[0]));
    chk({tag, "_wrap"}, 32'(ia.wrap), 32'(w));
    chk({tag, "_zero_err"}, 32'(ia.zero_err), 32'(z));
    chk({tag, "_period"}, 32'(ia.period), 32'(p));
  endtask
  initial begin
    v[0] = '{1'b1, 1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0, 16'd0};
    v[1] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b10100, 1'b0, 1'b0, 16'd0};
    v[2] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b01010, 1'b0, 1'b0, 16'd0};
    v[3] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b01010, 1'b0, 1'b0, 16'd0};
    v[4] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b00101, 1'b0, 1'b0, 16'd0};
    v[5] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0, 1'b1, 16'd0};
    v[6] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0, 16'd0};
    v[7] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b10100, 1'b0, 1'b0, 16'd0};
    v[8] = '{1'b0, 1'b1, 1'b1, 5'b00111, 5'b00111, 1'b0, 1'b0, 16'd0};
    v[9] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b10111, 1'b0, 1'b0, 16'd0};
    v[10] = '{1'b1, 1'b1, 1'b1, 5'b01000, 5'b00001, 1'b0, 1'b0, 16'd0};
    rst = 1'b1;
    {ia.step, ia.load, ia.load_data} = '0;
    {ib.step, ib.load, ib.load_data} = '0;
    {ic.step, ic.load, ic.load_data} = '0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = v[i].r;
      ia.step = v[i].s;
      ia.load = v[i].l;
      ia.load_data = v[i].d;
      @(negedge clk);
      check_a($sformatf("vec%0d", i), v[i].q, v[i].w, v[i].z, v[i].p);
    end
    rst = 1'b0;
    {ia.step, ia.load, ia.load_data} = '0;
    // full period from SEED, twice back to back
    ia.step = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (i == 30 || i == 32 || i == 61) chk($sformatf("galois_wrap_step%0d", i), 32'(ia.wrap), 32'd0);
      if (i == 31 || i == 62) check_a($sformatf("galois_wrap%0d", i), 5'b00001, 1'b1, 1'b0, 16'd31);
    end
    ia.step = 1'b0;
    @(negedge clk);
    check_a("hold_after_wrap", 5'b00001, 1'b0, 1'b0, 16'd31);
    // run-time seed: wrap returns to the loaded value
    ia.load = 1'b1;
    ia.load_data = 5'b00111;
    @(negedge clk);
    ia.load = 1'b0;
    check_a("load_seed", 5'b00111, 1'b0, 1'b0, 16'd31);
    ia.step = 1'b1;
    repeat (30) @(negedge clk);
    chk("seed_prewrap", 32'(ia.wrap), 32'd0);
    @(negedge clk);
    check_a("seed_wrap", 5'b00111, 1'b1, 1'b0, 16'd31);
    // zero load mid-run must clear cnt (else period would read 34)
    repeat (3) @(negedge clk);
    ia.load = 1'b1;
    ia.load_data = 5'b00000;
    @(negedge clk);
    ia.load = 1'b0;
    check_a("zero_load", 5'b00001, 1'b0, 1'b1, 16'd31);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (i == 1) chk("zero_err_pulse", 32'(ia.zero_err), 32'd0);
    end
    ia.step = 1'b0;
    ia.load = 1'b1;
    ia.load_data = 5'b00110;
    @(negedge clk);
    ia.load = 1'b0;
    chk("cnt_cleared_wrap", 32'(ia.period), 32'd31);
    // reset in the middle of a run drops the pending step
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ia.step = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_a("reset_midrun", 5'b00001, 1'b0, 1'b0, 16'd0);
    ia.step = 1'b0;
    // Fibonacci form and clamped 4-bit period counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ib.step = 1'b1;
    ic.step = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (i == 1) chk("fib_q1", 32'(ib.q), 32'b10000);
      if (i == 2) chk("fib_q2", 32'(ib.q), 32'b01000);
      if (i == 30) chk("fib_prewrap", 32'(ib.wrap), 32'd0);
      if (i == 30) chk("cw4_prewrap", 32'(ic.wrap), 32'd0);
    end
    chk("fib_wrap", 32'(ib.wrap), 32'd1);
    chk("fib_q31", 32'(ib.q), 32'b00001);
    chk("fib_period", 32'(ib.period), 32'd31);
    chk("cw4_wrap", 32'(ic.wrap), 32'd1);
    chk("cw4_q31", 32'(ic.q), 32'b00001);
    chk("cw4_period", 32'(ic.period), 32'd15);
    ib.step = 1'b0;
    ic.step = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
